// File: rtl/msrh_fetch_seq_if.sv
// Handshake bundle between the fetch sequencer and its environment
// (flush, TLB/I-cache request/response, refill, instruction buffer, perf).
interface msrh_fetch_seq_if #(
  parameter int unsigned VADDR_W = 39,
  parameter int unsigned EPOCH_W = 2
);
  logic               i_flush_valid;
  logic [VADDR_W-1:0] i_flush_vaddr;
  logic               o_req_valid;
  logic [VADDR_W-1:0] o_req_vaddr;
  logic [EPOCH_W-1:0] o_req_epoch;
  logic               i_req_ready;
  logic               i_resp_valid;
  logic [VADDR_W-1:0] i_resp_vaddr;
  logic [EPOCH_W-1:0] i_resp_epoch;
  logic [1:0]         i_resp_status;
  logic               i_refill_done;
  logic               i_ibuf_ready;
  logic               o_ibuf_valid;
  logic [VADDR_W-1:0] o_ibuf_vaddr;
  logic               o_ibuf_except;
  logic [2:0]         o_inflight;
  logic [31:0]        o_perf_replay_cnt;
  logic [31:0]        o_perf_stale_cnt;

  modport master (
    input  i_flush_valid, i_flush_vaddr, i_req_ready,
    input  i_resp_valid, i_resp_vaddr, i_resp_epoch, i_resp_status,
    input  i_refill_done, i_ibuf_ready,
    output o_req_valid, o_req_vaddr, o_req_epoch,
    output o_ibuf_valid, o_ibuf_vaddr, o_ibuf_except,
    output o_inflight, o_perf_replay_cnt, o_perf_stale_cnt
  );

  modport slave (
    output i_flush_valid, i_flush_vaddr, i_req_ready,
    output i_resp_valid, i_resp_vaddr, i_resp_epoch, i_resp_status,
    output i_refill_done, i_ibuf_ready,
    input  o_req_valid, o_req_vaddr, o_req_epoch,
    input  o_ibuf_valid, o_ibuf_vaddr, o_ibuf_except,
    input  o_inflight, o_perf_replay_cnt, o_perf_stale_cnt
  );
endinterface

// File: rtl/msrh_fetch_seq.sv
// Fetch-address sequencer: owns the fetch PC, issues epoch-tagged block requests,
// forwards current-epoch hits and replays on miss/back-pressure. FETCH_SEQ_PERF_EN adds perf counters.
module msrh_fetch_seq #(
  parameter int unsigned       VADDR_W      = 39,
  parameter int unsigned       FETCH_B      = 16,
  parameter int unsigned       MAX_INFLIGHT = 2,
  parameter int unsigned       EPOCH_W      = 2,
  parameter logic [VADDR_W-1:0] PC_INIT     = VADDR_W'(64'h8000_0000)
) (
  input logic              i_clk,
  input logic              i_reset_n,
  msrh_fetch_seq_if.master bus
);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_WAIT_FILL = 3'd2,
    ST_WAIT_IBUF = 3'd3,
    ST_HALT_EXC  = 3'd4
  } state_e;

  localparam logic [1:0] RS_HIT      = 2'd0;
  localparam logic [1:0] RS_IC_MISS  = 2'd1;
  localparam logic [1:0] RS_TLB_MISS = 2'd2;
  localparam logic [1:0] RS_EXCEPT   = 2'd3;

  localparam logic [VADDR_W-1:0] BLK_MASK = VADDR_W'(FETCH_B - 1);
  localparam logic [VADDR_W-1:0] BLK_STEP = VADDR_W'(FETCH_B);
  localparam logic [2:0]         MAX_INF  = 3'(MAX_INFLIGHT);

  function automatic logic [VADDR_W-1:0] next_block(input logic [VADDR_W-1:0] pc);
    return (pc & ~BLK_MASK) + BLK_STEP;
  endfunction

  state_e             state_q, state_d;
  logic [VADDR_W-1:0] pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [2:0]         inflight_q, inflight_d;

  logic resp_live_s;
  logic miss_s;
  logic fwd_s;
  logic replay_s;
  logic req_valid_s;
  logic accept_s;

  // A response is acted upon only if it carries the live epoch and no redirect or halt masks it.
  always_comb begin
    resp_live_s = bus.i_resp_valid && (bus.i_resp_epoch == epoch_q) && !bus.i_flush_valid &&
                  (state_q != ST_HALT_EXC) && (state_q != ST_INIT);
    miss_s      = (bus.i_resp_status == RS_IC_MISS) || (bus.i_resp_status == RS_TLB_MISS);
    fwd_s       = resp_live_s && !miss_s && bus.i_ibuf_ready;
    replay_s    = resp_live_s && !fwd_s;
    req_valid_s = (state_q == ST_RUN) && !bus.i_flush_valid &&
                  ((inflight_q < MAX_INF) || bus.i_resp_valid) && !replay_s;
    accept_s    = req_valid_s && bus.i_req_ready;
  end

  assign bus.o_req_valid   = req_valid_s;
  assign bus.o_req_vaddr   = pc_q;
  assign bus.o_req_epoch   = epoch_q;
  assign bus.o_ibuf_valid  = fwd_s;
  assign bus.o_ibuf_vaddr  = bus.i_resp_vaddr;
  assign bus.o_ibuf_except = fwd_s && (bus.i_resp_status == RS_EXCEPT);
  assign bus.o_inflight    = inflight_q;

  // Next state, PC and epoch; flush outranks replay, which outranks a normal accept.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    inflight_d = inflight_q + {2'b00, accept_s} - {2'b00, bus.i_resp_valid};
    if (bus.i_flush_valid) begin
      state_d = ST_RUN;
      pc_d    = bus.i_flush_vaddr;
      epoch_d = epoch_q + EPOCH_W'(1'b1);
    end else if (replay_s) begin
      state_d = miss_s ? ST_WAIT_FILL : ST_WAIT_IBUF;
      pc_d    = bus.i_resp_vaddr;
      epoch_d = epoch_q + EPOCH_W'(1'b1);
    end else begin
      if (accept_s) begin
        pc_d = next_block(pc_q);
      end else begin
        pc_d = pc_q;
      end
      case (state_q)
        ST_INIT: state_d = ST_RUN;
        ST_RUN: begin
          if (fwd_s && (bus.i_resp_status == RS_EXCEPT)) begin
            state_d = ST_HALT_EXC;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_WAIT_FILL: begin
          if (bus.i_refill_done) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WAIT_FILL;
          end
        end
        ST_WAIT_IBUF: begin
          if (bus.i_ibuf_ready) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WAIT_IBUF;
          end
        end
        ST_HALT_EXC: state_d = ST_HALT_EXC;
        default:     state_d = ST_INIT;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_INIT;
      pc_q       <= PC_INIT;
      epoch_q    <= '0;
      inflight_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic        stale_s;
  logic [31:0] replay_cnt_q;
  logic [31:0] stale_cnt_q;

  // Every valid response not acted upon counts as dropped.
  assign stale_s = bus.i_resp_valid && !resp_live_s;

  // Wrapping performance counters.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      replay_cnt_q <= 32'd0;
      stale_cnt_q  <= 32'd0;
    end else begin
      if (replay_s) begin
        replay_cnt_q <= replay_cnt_q + 32'd1;
      end
      if (stale_s) begin
        stale_cnt_q <= stale_cnt_q + 32'd1;
      end
    end
  end

  assign bus.o_perf_replay_cnt = replay_cnt_q;
  assign bus.o_perf_stale_cnt  = stale_cnt_q;
`else
  assign bus.o_perf_replay_cnt = 32'd0;
  assign bus.o_perf_stale_cnt  = 32'd0;
`endif

`ifdef SIMULATION
  msrh_fetch_seq_chk #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_chk (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .accept     (accept_s),
    .resp_valid (bus.i_resp_valid),
    .inflight   (inflight_q)
  );
`endif

endmodule

`ifdef SIMULATION
module msrh_fetch_seq_chk #(
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input logic       clk,
  input logic       rst_n,
  input logic       accept,
  input logic       resp_valid,
  input logic [2:0] inflight
);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_valid && !accept && (inflight == 3'd0)))
    else $fatal(1, "msrh_fetch_seq: inflight underflow");

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(accept && !resp_valid && (inflight >= 3'(MAX_INFLIGHT))))
    else $fatal(1, "msrh_fetch_seq: inflight overflow");
endmodule
`endif

// File: tb/tb_msrh_fetch_seq.sv
// Directed scoreboard bench for msrh_fetch_seq: stimulus pushes expected requests/blocks,
// a negedge monitor pops and compares on every accepted request and forwarded block.
module tb_msrh_fetch_seq;
  localparam int unsigned VADDR_W = 39;
  localparam int unsigned EPOCH_W = 2;
  localparam logic [1:0] HIT = 2'd0, IC_MISS = 2'd1, EXCEPT = 2'd3;

  typedef struct { logic [VADDR_W-1:0] va; logic [EPOCH_W-1:0] ep; } req_t;
  typedef struct { logic [VADDR_W-1:0] va; logic exc; } blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  req_t req_q[$];
  blk_t blk_q[$];
  req_t er;
  blk_t eb;

  always #5 clk = ~clk;

  msrh_fetch_seq_if #(.VADDR_W(VADDR_W), .EPOCH_W(EPOCH_W)) bus ();

  msrh_fetch_seq #(
    .VADDR_W(VADDR_W), .FETCH_B(16), .MAX_INFLIGHT(2), .EPOCH_W(EPOCH_W),
    .PC_INIT(39'h80000000)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic [VADDR_W-1:0] va, input logic [EPOCH_W-1:0] ep);
    req_t r;
    r.va = va; r.ep = ep;
    req_q.push_back(r);
  endtask

  task automatic exp_blk(input logic [VADDR_W-1:0] va, input logic exc);
    blk_t b;
    b.va = va; b.exc = exc;
    blk_q.push_back(b);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.i_flush_valid = 1'b0;
    bus.i_resp_valid  = 1'b0;
    bus.i_refill_done = 1'b0;
  endtask

  task automatic resp(input logic [VADDR_W-1:0] va, input logic [EPOCH_W-1:0] ep, input logic [1:0] st);
    bus.i_resp_valid  = 1'b1;
    bus.i_resp_vaddr  = va;
    bus.i_resp_epoch  = ep;
    bus.i_resp_status = st;
  endtask

  task automatic flush(input logic [VADDR_W-1:0] va);
    bus.i_flush_valid = 1'b1;
    bus.i_flush_vaddr = va;
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the capturing edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_req_valid && bus.i_req_ready) begin
        if (req_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_req: got vaddr 0x%0h expected no request", bus.o_req_vaddr);
        end else begin
          er = req_q.pop_front();
          check("req_vaddr", 64'(bus.o_req_vaddr), 64'(er.va));
          check("req_epoch", 64'(bus.o_req_epoch), 64'(er.ep));
        end
      end
      if (bus.o_ibuf_valid) begin
        if (blk_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_blk: got vaddr 0x%0h expected no block", bus.o_ibuf_vaddr);
        end else begin
          eb = blk_q.pop_front();
          check("ibuf_vaddr", 64'(bus.o_ibuf_vaddr), 64'(eb.va));
          check("ibuf_except", 64'(bus.o_ibuf_except), 64'(eb.exc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_flush_valid = 1'b0; bus.i_flush_vaddr = '0;
    bus.i_req_ready = 1'b0;   bus.i_resp_valid = 1'b0;
    bus.i_resp_vaddr = '0;    bus.i_resp_epoch = '0; bus.i_resp_status = HIT;
    bus.i_refill_done = 1'b0; bus.i_ibuf_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 64'(bus.o_req_valid), 64'd0);
    check("rst_ibuf_valid", 64'(bus.o_ibuf_valid), 64'd0);
    check("rst_inflight", 64'(bus.o_inflight), 64'd0);
    check("rst_perf_replay", 64'(bus.o_perf_replay_cnt), 64'd0);
    rst_n = 1'b1;
    #1 check("init_no_req", 64'(bus.o_req_valid), 64'd0);
    cyc();

    // Streaming hits with two-cycle latency
    bus.i_req_ready = 1'b1;
    exp_req(39'h80000000, 2'd0); cyc();
    exp_req(39'h80000010, 2'd0); cyc();
    resp(39'h80000000, 2'd0, HIT); exp_req(39'h80000020, 2'd0); exp_blk(39'h80000000, 1'b0);
    #1 check("s1_inflight_cap", 64'(bus.o_inflight), 64'd2);
    cyc();
    resp(39'h80000010, 2'd0, HIT); exp_req(39'h80000030, 2'd0); exp_blk(39'h80000010, 1'b0); cyc();
    bus.i_req_ready = 1'b0;
    resp(39'h80000020, 2'd0, HIT); exp_blk(39'h80000020, 1'b0); cyc();
    resp(39'h80000030, 2'd0, HIT); exp_blk(39'h80000030, 1'b0); cyc();
    #1 check("s1_drained", 64'(bus.o_inflight), 64'd0);

    // I-cache miss replay
    bus.i_req_ready = 1'b1;
    exp_req(39'h80000040, 2'd0); cyc();
    exp_req(39'h80000050, 2'd0); cyc();
    resp(39'h80000040, 2'd0, IC_MISS);
    #1 check("s2_no_issue_on_replay", 64'(bus.o_req_valid), 64'd0);
    cyc();
    resp(39'h80000050, 2'd0, HIT);
    #1 check("s2_stale_not_fwd", 64'(bus.o_ibuf_valid), 64'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1 check("s2_wait_fill_no_req", 64'(bus.o_req_valid), 64'd0);
      cyc();
    end
    bus.i_refill_done = 1'b1;
    #1 check("s2_refill_cycle_no_req", 64'(bus.o_req_valid), 64'd0);
    cyc();
    exp_req(39'h80000040, 2'd1); cyc();
    bus.i_req_ready = 1'b0; cyc();
    resp(39'h80000040, 2'd1, HIT); exp_blk(39'h80000040, 1'b0); cyc();

    // Flush with two requests in flight
    bus.i_req_ready = 1'b1;
    exp_req(39'h80000050, 2'd1); cyc();
    exp_req(39'h80000060, 2'd1); cyc();
    flush(39'h80001006);
    #1 check("s3_flush_no_req", 64'(bus.o_req_valid), 64'd0);
    check("s3_inflight_kept", 64'(bus.o_inflight), 64'd2);
    cyc();
    resp(39'h80000050, 2'd1, HIT); exp_req(39'h80001006, 2'd2); cyc();
    resp(39'h80000060, 2'd1, HIT); exp_req(39'h80001010, 2'd2); cyc();
    bus.i_req_ready = 1'b0;
    resp(39'h80001006, 2'd2, HIT); exp_blk(39'h80001006, 1'b0); cyc();
    resp(39'h80001010, 2'd2, HIT); exp_blk(39'h80001010, 1'b0); cyc();

    // Instruction-buffer back-pressure replay
    bus.i_req_ready = 1'b1;
    exp_req(39'h80001020, 2'd2); cyc();
    bus.i_req_ready = 1'b0; cyc();
    bus.i_ibuf_ready = 1'b0;
    resp(39'h80001020, 2'd2, HIT);
    #1 check("s4_backpressure_no_fwd", 64'(bus.o_ibuf_valid), 64'd0);
    cyc();
    bus.i_req_ready = 1'b1;
    #1 check("s4_wait_ibuf_no_req", 64'(bus.o_req_valid), 64'd0);
    cyc();
    bus.i_ibuf_ready = 1'b1;
    #1 check("s4_release_cycle_no_req", 64'(bus.o_req_valid), 64'd0);
    cyc();
    exp_req(39'h80001020, 2'd3); cyc();
    bus.i_req_ready = 1'b0; cyc();
    resp(39'h80001020, 2'd3, HIT); exp_blk(39'h80001020, 1'b0); cyc();

    // Fetch exception halts until redirect (epoch wraps 3 -> 0)
    bus.i_req_ready = 1'b1;
    exp_req(39'h80001030, 2'd3); cyc();
    bus.i_req_ready = 1'b0; cyc();
    resp(39'h80001030, 2'd3, EXCEPT); exp_blk(39'h80001030, 1'b1); cyc();
    bus.i_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 check("s5_halt_no_req", 64'(bus.o_req_valid), 64'd0);
      cyc();
    end
    flush(39'h80002000); cyc();
    exp_req(39'h80002000, 2'd0); cyc();
    bus.i_req_ready = 1'b0; cyc();
    resp(39'h80002000, 2'd0, HIT); exp_blk(39'h80002000, 1'b0); cyc();

    // Flush over a live hit, then four back-to-back flushes
    bus.i_req_ready = 1'b1;
    exp_req(39'h80002010, 2'd0); cyc();
    bus.i_req_ready = 1'b0; cyc();
    resp(39'h80002010, 2'd0, HIT); flush(39'h80003000);
    #1 check("s6_flush_kills_hit", 64'(bus.o_ibuf_valid), 64'd0);
    cyc();
    flush(39'h80003004); cyc();
    flush(39'h80003008); cyc();
    flush(39'h8000300C); cyc();
    bus.i_req_ready = 1'b1;
    exp_req(39'h8000300C, 2'd0); cyc();
    bus.i_req_ready = 1'b0;
    #1 check("s6_aligned_after_redirect", 64'(bus.o_req_vaddr), 64'h80003010);
    cyc();
    resp(39'h8000300C, 2'd0, HIT); exp_blk(39'h8000300C, 1'b0); cyc();

`ifdef FETCH_SEQ_PERF_EN
    check("perf_replay", 64'(bus.o_perf_replay_cnt), 64'd2);
    check("perf_stale", 64'(bus.o_perf_stale_cnt), 64'd4);
`else
    check("perf_replay_tied", 64'(bus.o_perf_replay_cnt), 64'd0);
    check("perf_stale_tied", 64'(bus.o_perf_stale_cnt), 64'd0);
`endif

    // Reset in mid-operation
    bus.i_req_ready = 1'b1;
    exp_req(39'h80003010, 2'd0); cyc();
    rst_n = 1'b0;
    #1 check("s7_rst_inflight", 64'(bus.o_inflight), 64'd0);
    check("s7_rst_req_valid", 64'(bus.o_req_valid), 64'd0);
    cyc();
    rst_n = 1'b1;
    #1 check("s7_init_no_req", 64'(bus.o_req_valid), 64'd0);
    cyc();
    exp_req(39'h80000000, 2'd0); cyc();
    bus.i_req_ready = 1'b0; cyc();

    check("req_queue_empty", 64'(req_q.size()), 64'd0);
    check("blk_queue_empty", 64'(blk_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
